// File: rtl/byte_packer_pkg.sv
// Shared definitions for the byte packer: default geometry, the packer
// state type and the width helper used to size the lane count.
package byte_packer_pkg;

  localparam int BYTE_W_DEF     = 8;
  localparam int WORD_BYTES_DEF = 4;

  // FILL: accumulator empty, next byte lands in lane 0.
  // PART: at least one lane written, word not yet complete.
  typedef enum logic {
    FILL = 1'b0,
    PART = 1'b1
  } state_t;

  // Smallest number of bits able to index 'value' distinct codes.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Byte packer: collects bytes little-endian into a WORD_BYTES-wide word and
// emits it when the last lane is filled or a byte arrives with in_last.
// Optional feature macro BYTE_PACKER_PARITY_EN adds out_parity, the XOR of
// all out_word bits, registered alongside out_word.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int WORD_BYTES = WORD_BYTES_DEF,
  parameter int BYTE_W     = BYTE_W_DEF
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  input  logic [BYTE_W-1:0]                        in_byte,
  input  logic                                     in_last,
  output logic                                     in_ready,
  output logic                                     out_valid,
  output logic [WORD_BYTES*BYTE_W-1:0]             out_word,
  output logic [clog2(WORD_BYTES+1)-1:0]           out_bytes,
  input  logic                                     out_ready
`ifdef BYTE_PACKER_PARITY_EN
  ,
  output logic                                     out_parity
`endif
);

  localparam int CW = clog2(WORD_BYTES + 1);
  localparam int WW = WORD_BYTES * BYTE_W;

  state_t          state, state_nxt;
  logic [CW-1:0]   idx, idx_nxt;
  logic [WW-1:0]   acc, acc_nxt, acc_ins;
  logic            take;
  logic            last_lane;
  logic            done;

  // A byte may enter whenever the output slot is free or being drained now.
  assign in_ready  = !out_valid || out_ready;
  assign take      = in_valid && in_ready;
  assign last_lane = (idx == CW'(WORD_BYTES - 1));
  assign done      = take && (last_lane || in_last);

  // Accumulator view with the incoming byte placed in the current lane.
  always_comb begin
    acc_ins = acc;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (idx == CW'(i)) acc_ins[BYTE_W*i +: BYTE_W] = in_byte;
    end
  end

  // Next-state logic: fill lanes, or wrap to an empty accumulator on completion.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    acc_nxt   = acc;
    if (take) begin
      if (done) begin
        state_nxt = FILL;
        idx_nxt   = '0;
        acc_nxt   = '0;
      end else begin
        state_nxt = PART;
        idx_nxt   = idx + CW'(1);
        acc_nxt   = acc_ins;
      end
    end
  end

  // Packer state register: lane counter, accumulator and FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      idx   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      acc   <= acc_nxt;
    end
  end

  // Output register: a completing byte loads a new word (replacing a word
  // drained in the same cycle); otherwise the word holds until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_bytes <= '0;
    end else if (done) begin
      out_valid <= 1'b1;
      out_word  <= acc_ins;
      out_bytes <= idx + CW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BYTE_PACKER_PARITY_EN
  // Parity of the word, captured together with out_word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else if (done) begin
      out_parity <= ^acc_ins;
    end
  end
`endif

endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 4, bytes per output word (legal range 2..8).
REQ-002 SHALL have parameter BYTE_W, default 8, width of one byte lane.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  in_byte is valid this cycle.
REQ-007 in_byte  input  BYTE_W  byte to insert.
REQ-008 in_last  input  1  marks this byte as the final byte of a message; forces word emission.
REQ-009 in_ready  output  1  packer accepts a byte this cycle.
REQ-010 out_valid  output  1  out_word is valid.
REQ-011 out_word  output  WORD_BYTES*BYTE_W  assembled word.
REQ-012 out_bytes  output  clog2(WORD_BYTES+1)  count of valid lanes in out_word (1..WORD_BYTES).
REQ-013 out_ready  input  1  consumer takes the word this cycle.

Function
REQ-014 SHALL transfer a byte when in_valid && in_ready are both high at the rising clock edge, and a word when out_valid && out_ready are both high.
REQ-015 SHALL write the byte accepted at lane index idx into accumulator bits [BYTE_W*idx +: BYTE_W]; the first byte goes to lane 0 (little-endian).
REQ-016 SHALL keep a lane counter idx; reset value is 0; it increments by 1 per accepted byte.
REQ-017 SHALL have two states: FILL (idx == 0, accumulator empty) and PART (idx > 0). FILL->PART on an accepted byte without completion; PART->FILL on completion.
REQ-018 Completion occurs when the accepted byte has idx == WORD_BYTES-1, or has in_last == 1.
REQ-019 On completion, SHALL load the output register with the accumulator (including the completing byte), set out_bytes = idx+1, and set out_valid = 1 on the next cycle. idx wraps to 0 and the accumulator clears to 0 in the same cycle.
REQ-020 Lanes not written before completion SHALL read as 0 in out_word.
REQ-021 in_ready SHALL be !out_valid || out_ready, gating every byte, not only completing bytes; in_ready SHALL NOT depend on in_valid.
REQ-022 Simultaneous completion and output drain SHALL hand over with no bubble: out_valid stays 1 and the new word replaces the old.
REQ-023 out_word, out_bytes and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-024 Latency SHALL be exactly 1 cycle from the completing byte's accept edge to out_valid high.
REQ-025 in_last on a byte with idx == WORD_BYTES-1 SHALL produce exactly one word with out_bytes = WORD_BYTES.

Reset
REQ-026 On rst: idx = 0, accumulator = 0, out_valid = 0, out_word = 0, out_bytes = 0, out_parity = 0 (if present), state = FILL.
REQ-027 Reset asserted mid-word SHALL discard the partial word with no emission; a pending out_word is dropped.
REQ-028 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-029 With macro BYTE_PACKER_PARITY_EN defined, SHALL add output out_parity (input... output, 1 bit), the XOR of all out_word bits, registered with out_word and valid with out_valid.
REQ-030 Without BYTE_PACKER_PARITY_EN, out_parity SHALL NOT exist and no parity logic is built.

Structure
REQ-031 A shared package byte_packer_pkg SHALL hold: constant BYTE_W_DEF = 8, constant WORD_BYTES_DEF = 4, the state enum type (FILL, PART), and a count-width function clog2.
REQ-032 SHALL be a single module; no sub-module is natural (accumulator, counter and output register are all trivial).

Verification
REQ-033 Bytes FE, CA, CE, FA back-to-back, out_ready = 1 -> one word 0xFACE_CAFE, out_bytes = 4, out_valid high 1 cycle after the 4th accept.
REQ-034 Bytes 11, 22 with in_last on 22 -> out_word 0x0000_2211, out_bytes = 2; next word starts at lane 0.
REQ-035 Two full words back-to-back with out_ready held 0 until the second completes -> in_ready drops after word 1 is emitted; word 1 held stable; no byte lost; word 2 emitted after out_ready rises.
REQ-036 rst pulse after 3 bytes accepted -> no word emitted; next 4 bytes 01, 02, 03, 04 -> 0x0403_0201.
REQ-037 Completion in the same cycle as out_ready drains the previous word -> out_valid stays 1; the new word appears on the next edge; no bubble and no duplicate.
REQ-038 With BYTE_PACKER_PARITY_EN, word 0xFACE_CAFE -> out_parity = 0; word 0x0000_0001 -> out_parity = 1.
